uart_tx_engine: RTL
===================

Name: uart_tx_engine

Overview:
UART transmit engine, the send-side counterpart of the receive path. It accepts one byte per load, builds a fixed 11-bit serial frame and shifts it out LSB first on tx. The frame is start bit, 7 or 8 data bits, optional parity, and stop/idle ones. Frame format is selected by eight, pen and ohel, the same format controls the receiver uses. The block sits between the CPU-side transmit register interface and the tx pin.

Parameters:
CNT_W, 19, width of the bit-time counter and of baud_k.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle strobe; request to send data_in
data_in  input  8  byte to transmit
eight  input  1  1 = 8 data bits, 0 = 7 data bits (data_in[6:0])
pen  input  1  parity enable
ohel  input  1  parity sense: 0 = even, 1 = odd
baud_k  input  CNT_W  clocks per bit minus 1
tx  output  1  serial line, idles high
txrdy  output  1  1 = idle, able to accept load
tx_done  output  1  one-cycle pulse at frame completion

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on port reset sampled at the clk rising edge.
- Reset values: tx=1, txrdy=1, tx_done=0. Shift register = all ones; bit counter and bit-time counter = 0.
- Reset mid-frame aborts the frame. The cycle after reset is sampled, tx=1 and txrdy=1; no tx_done pulse.

State machine:
- IDLE:
  - txrdy=1, tx=1.
  - If load=1 in cycle N: latch data_in, eight, pen, ohel and baud_k; go to SEND.
  - In cycle N+1: txrdy=0 and tx=0 (start bit).
- SEND:
  - The bit-time counter counts 0..baud_k; each bit is held for baud_k+1 clocks.
  - At terminal count the shift register shifts right, filling with 1, and the bit counter increments.
  - After the 11th bit time completes, go to IDLE: txrdy=1, tx=1, tx_done=1 for exactly one cycle.

Frame timing:
- Total busy time is 11×(baud_k+1) clocks, counted from cycle N+1 to the last tx bit cycle inclusive.
- baud_k=0 gives 1 clock per bit (11-cycle frame).
- baud_k changes during SEND have no effect; the latched copy is used.

Frame construction (bit0 sent first; p7 = ^data_in[6:0], p8 = ^data_in[7:0]; parity bit = p XOR ohel):
- eight=0, pen=0: {1, 1, 1, d[6:0], 0}
- eight=0, pen=1: {1, 1, par7, d[6:0], 0}
- eight=1, pen=0: {1, 1, d[7:0], 0}
- eight=1, pen=1: {1, par8, d[7:0], 0}
- The frame is always 11 bit times. Unused positions are transmitted as 1 (extra stop time), so receiver bit alignment is format-independent.
- With eight=0, data_in[7] is ignored.

Boundary conditions:
- load while txrdy=0: ignored entirely. No latch, no queuing, the frame in progress is unaffected.
- load in the same cycle tx_done/txrdy returns to 1: accepted (back-to-back frames). The next start bit begins the following cycle, so there is no idle gap beyond the frame's own stop bits.
- load held high continuously: one frame per 11×(baud_k+1)+1 clocks.
- Format inputs changing during SEND: no effect until the next load.
- reset and load asserted together: reset wins; the load is dropped.

Test Plan:
- Reset then idle: assert reset 2 cycles with load=1 → tx=1, txrdy=1, tx_done=0 throughout; no frame starts.
- 8 data bits, even parity: eight=1, pen=1, ohel=0, data_in=8'hA5, baud_k=3, single load pulse. Required response:
  - tx sequence, each bit held 4 clocks: 0,1,0,1,0,0,1,0,1,0,1.
  - txrdy low for exactly 44 clocks.
  - tx_done pulses once, in the cycle txrdy rises.
- 7 data bits, odd parity: eight=0, pen=1, ohel=1, data_in=8'hC1 (d[6:0]=7'h41, two ones), baud_k=0. Required response:
  - bits 0,1,0,0,0,0,0,1,1,1,1 on 11 consecutive clocks.
  - parity bit = 1, and bit7 of data_in is ignored.
- Busy load and back-to-back: during a frame, pulse load with 8'h00 → ignored, the current frame is unchanged. Then pulse load with 8'hFF in the tx_done cycle (eight=1, pen=0) → the start bit appears on the next clock, and the frame is 0, eight 1s, 1, 1.
- Config change mid-frame: start 8'h55 with eight=1, pen=1, ohel=0, baud_k=1. Mid-frame set baud_k=7, ohel=1, eight=0 → the frame still completes in 22 clocks with even parity bit 0.
- Reset mid-frame: assert reset at the 5th bit time → the next cycle tx=1 and txrdy=1, with no tx_done. A subsequent load of 8'h3C transmits a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine_if
// Description : Load/format/status bundle between the transmit register
//               interface and the UART transmit engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_engine_if #(
    parameter int CNT_W = 19
);
    logic             load;
    logic [7:0]       data_in;
    logic             eight;
    logic             pen;
    logic             ohel;
    logic [CNT_W-1:0] baud_k;
    logic             tx;
    logic             txrdy;
    logic             tx_done;

    modport master (
        output load, data_in, eight, pen, ohel, baud_k,
        input  tx, txrdy, tx_done
    );

    modport slave (
        input  load, data_in, eight, pen, ohel, baud_k,
        output tx, txrdy, tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : UART transmitter; shifts a fixed 11-bit frame out LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
    parameter int CNT_W = 19
) (
    input  wire logic       clk,
    input  wire logic       reset,
    uart_tx_engine_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [3:0]  c_LAST_BIT = 4'd10;
    localparam logic [10:0] c_IDLE_LINE = 11'h7FF;

    state_t           r_state;
    logic [10:0]      r_shift;
    logic [3:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0] r_baud_k;
    logic             r_txrdy;
    logic             r_tx_done;

    logic             w_par7;
    logic             w_par8;
    logic             w_bit8;
    logic             w_bit9;
    logic [10:0]      w_frame;

    // Unused format positions stay 1 so every frame is 11 bit times long.
    always_comb begin
        w_par7  = (^bus.data_in[6:0]) ^ bus.ohel;
        w_par8  = (^bus.data_in[7:0]) ^ bus.ohel;
        w_bit8  = bus.eight ? bus.data_in[7] : (bus.pen ? w_par7 : 1'b1);
        w_bit9  = (bus.eight && bus.pen) ? w_par8 : 1'b1;
        w_frame = {1'b1, w_bit9, w_bit8, bus.data_in[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= c_IDLE_LINE;
            r_bit_cnt  <= 4'd0;
            r_baud_cnt <= '0;
            r_baud_k   <= '0;
            r_txrdy    <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_shift    <= w_frame;
                        r_baud_k   <= bus.baud_k;
                        r_bit_cnt  <= 4'd0;
                        r_baud_cnt <= '0;
                        r_txrdy    <= 1'b0;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_baud_cnt == r_baud_k) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {1'b1, r_shift[10:1]};
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= 4'd0;
                            r_shift   <= c_IDLE_LINE;
                            r_txrdy   <= 1'b1;
                            r_tx_done <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_shift <= c_IDLE_LINE;
                    r_txrdy <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx      = r_shift[0];
    assign bus.txrdy   = r_txrdy;
    assign bus.tx_done = r_tx_done;

endmodule
`default_nettype wire
